// File: rtl/spmv_kernel_launcher_if.sv
// Launcher-to-kernel link: one job descriptor channel and one row-completion beat channel.
// The master side is the launcher and the slave side is the SpMV kernel.
interface spmv_kernel_launcher_if;
  logic        m_job_valid;
  logic        m_job_ready;
  logic [31:0] m_job_row_num;
  logic [31:0] m_job_nnz_num;
  logic        s_row_done_valid;
  logic        s_row_done_ready;

  modport master (
    output m_job_valid, m_job_row_num, m_job_nnz_num, s_row_done_ready,
    input  m_job_ready, s_row_done_valid
  );

  modport slave (
    input  m_job_valid, m_job_row_num, m_job_nnz_num, s_row_done_ready,
    output m_job_ready, s_row_done_valid
  );
endinterface

// File: rtl/spmv_kernel_launcher.sv
// Per-kernel launch sequencer: edge-detects start, issues one job descriptor,
// counts row-completion beats and reports busy/done/error plus a run-cycle counter.
module spmv_kernel_launcher #(
  parameter logic [31:0] MAX_ROWS = 32'h0010_0000,
  parameter int          CNT_W    = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [31:0]             cfg_ctrl,
  input  logic [31:0]             cfg_row_num,
  input  logic [31:0]             cfg_nnz_num,
  spmv_kernel_launcher_if.master  job_if,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [CNT_W-1:0]        rows_done,
  output logic [CNT_W-1:0]        cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_start_d;
  logic               r_done;
  logic               r_error;
  logic [CNT_W-1:0]   r_rows_done;
  logic [CNT_W-1:0]   r_cycle_count;
  logic [31:0]        r_job_row_num;
  logic [31:0]        r_job_nnz_num;

  logic               w_launch;
  logic               w_abort;
  logic               w_handshake;
  logic               w_beat;
  logic               w_row_zero;
  logic               w_row_big;
  logic [CNT_W-1:0]   w_rows_next;
  logic               w_last_beat;

  assign w_launch    = cfg_ctrl[0] & ~r_start_d;
  assign w_abort     = cfg_ctrl[1];
  assign w_handshake = job_if.m_job_valid & job_if.m_job_ready;
  assign w_beat      = job_if.s_row_done_valid;
  assign w_row_zero  = (cfg_row_num == 32'd0);
  assign w_row_big   = (cfg_row_num > MAX_ROWS);
  assign w_rows_next = r_rows_done + CNT_W'(1);
  assign w_last_beat = w_beat && (w_rows_next == CNT_W'(r_job_row_num));

  // Decoded from the state register so reset drops the descriptor immediately.
  assign job_if.m_job_valid      = (r_state == S_ISSUE);
  assign job_if.m_job_row_num    = r_job_row_num;
  assign job_if.m_job_nnz_num    = r_job_nnz_num;
  assign job_if.s_row_done_ready = 1'b1;

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign error       = r_error;
  assign rows_done   = r_rows_done;
  assign cycle_count = r_cycle_count;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves w_state_next unassigned (no latch).
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_launch && !w_row_zero && !w_row_big) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_abort)          w_state_next = S_IDLE;
        else if (w_handshake) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_abort || w_last_beat) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_start_d     <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_rows_done   <= '0;
      r_cycle_count <= '0;
      r_job_row_num <= '0;
      r_job_nnz_num <= '0;
    end else begin
      r_start_d <= cfg_ctrl[0];
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_done        <= w_row_zero;
            r_error       <= w_row_big;
            r_rows_done   <= '0;
            r_cycle_count <= '0;
            r_job_row_num <= cfg_row_num;
            r_job_nnz_num <= cfg_nnz_num;
          end
          // A stray beat outranks the clear of a same-cycle launch.
          if (w_beat) r_error <= 1'b1;
        end
        S_ISSUE: begin
          if (w_abort || w_beat) r_error <= 1'b1;
          if (w_abort)          r_done        <= 1'b0;
          else if (w_handshake) r_cycle_count <= '0;
        end
        S_RUN: begin
          if (w_abort) begin
            r_error <= 1'b1;
            r_done  <= 1'b0;
          end else begin
            if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (w_beat)              r_rows_done   <= w_rows_next;
            if (w_last_beat)         r_done        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_kernel_launcher.sv
// Bench for spmv_kernel_launcher: table of job vectors plus hand-written corner sequences,
// with a descriptor scoreboard filled at launch and drained when the kernel accepts a descriptor.
module tb_spmv_kernel_launcher;

  localparam logic [31:0] MAX_ROWS = 32'h0010_0000;
  localparam int          CNT_W    = 32;

  logic              aclk;
  logic              areset;
  logic [31:0]       cfg_ctrl;
  logic [31:0]       cfg_row_num;
  logic [31:0]       cfg_nnz_num;
  logic              busy;
  logic              done;
  logic              error;
  logic [CNT_W-1:0]  rows_done;
  logic [CNT_W-1:0]  cycle_count;

  spmv_kernel_launcher_if bus ();

  spmv_kernel_launcher #(.MAX_ROWS(MAX_ROWS), .CNT_W(CNT_W)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .cfg_ctrl    (cfg_ctrl),
    .cfg_row_num (cfg_row_num),
    .cfg_nnz_num (cfg_nnz_num),
    .job_if      (bus.master),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .rows_done   (rows_done),
    .cycle_count (cycle_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] row;
    logic [31:0] nnz;
  } desc_t;

  typedef struct {
    logic [31:0] row;
    logic [31:0] nnz;
    int          ready_wait;
    int          gap;
    int          abort_after;
    bit          exp_issue;
    bit          exp_done;
    bit          exp_error;
    logic [31:0] exp_rows;
  } vec_t;

  desc_t sb[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Descriptor scoreboard: compare each accepted descriptor against the oldest launch.
  always @(negedge aclk) begin
    if (!areset && bus.m_job_valid && bus.m_job_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_descriptor", {32'd0, bus.m_job_row_num}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        desc_t d;
        d = sb.pop_front();
        check("desc_row_num", {32'd0, bus.m_job_row_num}, {32'd0, d.row});
        check("desc_nnz_num", {32'd0, bus.m_job_nnz_num}, {32'd0, d.nnz});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  vec_t vecs[6];

  initial begin
    int    cyc;
    int    n_beats;
    string tag;

    vecs[0] = '{row: 32'd3,           nnz: 32'd10, ready_wait: 0, gap: 0, abort_after: -1,
                exp_issue: 1'b1, exp_done: 1'b1, exp_error: 1'b0, exp_rows: 32'd3};
    vecs[1] = '{row: 32'd5,           nnz: 32'd0,  ready_wait: 5, gap: 1, abort_after: -1,
                exp_issue: 1'b1, exp_done: 1'b1, exp_error: 1'b0, exp_rows: 32'd5};
    vecs[2] = '{row: 32'd0,           nnz: 32'd7,  ready_wait: 0, gap: 0, abort_after: -1,
                exp_issue: 1'b0, exp_done: 1'b1, exp_error: 1'b0, exp_rows: 32'd0};
    vecs[3] = '{row: MAX_ROWS + 32'd1, nnz: 32'd1, ready_wait: 0, gap: 0, abort_after: -1,
                exp_issue: 1'b0, exp_done: 1'b0, exp_error: 1'b1, exp_rows: 32'd0};
    vecs[4] = '{row: 32'd1,           nnz: 32'd2,  ready_wait: 2, gap: 2, abort_after: -1,
                exp_issue: 1'b1, exp_done: 1'b1, exp_error: 1'b0, exp_rows: 32'd1};
    vecs[5] = '{row: 32'd4,           nnz: 32'd9,  ready_wait: 1, gap: 0, abort_after: 2,
                exp_issue: 1'b1, exp_done: 1'b0, exp_error: 1'b1, exp_rows: 32'd2};

    areset               = 1'b1;
    cfg_ctrl             = 32'd0;
    cfg_row_num          = 32'd0;
    cfg_nnz_num          = 32'd0;
    bus.m_job_ready      = 1'b0;
    bus.s_row_done_valid = 1'b0;
    #2;
    check("rst_busy",        {63'd0, busy}, 64'd0);
    check("rst_job_valid",   {63'd0, bus.m_job_valid}, 64'd0);
    check("rst_row_ready",   {63'd0, bus.s_row_done_ready}, 64'd1);
    check("rst_done",        {63'd0, done}, 64'd0);
    check("rst_error",       {63'd0, error}, 64'd0);
    check("rst_rows_done",   {32'd0, rows_done}, 64'd0);
    check("rst_cycle_count", {32'd0, cycle_count}, 64'd0);
    tick();
    tick();
    areset = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      tag = $sformatf("v%0d", v);
      cfg_row_num = vecs[v].row;
      cfg_nnz_num = vecs[v].nnz;
      cfg_ctrl    = 32'd0;
      tick();
      // Rejected launches keep ready high so any spurious descriptor reaches the scoreboard.
      bus.m_job_ready = !vecs[v].exp_issue;
      cfg_ctrl = 32'd1;
      if (vecs[v].exp_issue) sb.push_back('{row: vecs[v].row, nnz: vecs[v].nnz});
      tick();
      cfg_ctrl    = 32'd0;
      cfg_row_num = 32'hDEAD_BEEF;
      cyc = 0;
      if (!vecs[v].exp_issue) begin
        check({tag, "_job_valid"}, {63'd0, bus.m_job_valid}, 64'd0);
        tick();
        bus.m_job_ready = 1'b0;
      end else begin
        check({tag, "_issue_valid"}, {63'd0, bus.m_job_valid}, 64'd1);
        for (int w = 0; w < vecs[v].ready_wait; w++) begin
          tick();
          check({tag, "_bp_valid"},   {63'd0, bus.m_job_valid}, 64'd1);
          check({tag, "_bp_row_num"}, {32'd0, bus.m_job_row_num}, {32'd0, vecs[v].row});
          check({tag, "_bp_cycles"},  {32'd0, cycle_count}, 64'd0);
        end
        bus.m_job_ready = 1'b1;
        tick();
        bus.m_job_ready = 1'b0;
        check({tag, "_valid_after_hs"}, {63'd0, bus.m_job_valid}, 64'd0);
        check({tag, "_cycles_at_hs"},   {32'd0, cycle_count}, 64'd0);
        n_beats = (vecs[v].abort_after >= 0) ? vecs[v].abort_after : int'(vecs[v].row);
        for (int b = 0; b < n_beats; b++) begin
          for (int g = 0; g < vecs[v].gap; g++) begin
            tick();
            cyc++;
          end
          bus.s_row_done_valid = 1'b1;
          tick();
          cyc++;
          bus.s_row_done_valid = 1'b0;
        end
        if (vecs[v].abort_after >= 0) begin
          cfg_ctrl = 32'd2;
          tick();
          cfg_ctrl = 32'd0;
        end
        check({tag, "_cycle_count"}, {32'd0, cycle_count}, cyc);
      end
      check({tag, "_busy"},      {63'd0, busy}, 64'd0);
      check({tag, "_done"},      {63'd0, done}, {63'd0, vecs[v].exp_done});
      check({tag, "_error"},     {63'd0, error}, {63'd0, vecs[v].exp_error});
      check({tag, "_rows_done"}, {32'd0, rows_done}, {32'd0, vecs[v].exp_rows});
      check({tag, "_latched_row"}, {32'd0, bus.m_job_row_num}, {32'd0, vecs[v].row});
      check({tag, "_latched_nnz"}, {32'd0, bus.m_job_nnz_num}, {32'd0, vecs[v].nnz});
    end

    // Stray beat after the abort: error stays set and the count does not move.
    bus.s_row_done_valid = 1'b1;
    tick();
    bus.s_row_done_valid = 1'b0;
    check("stray_error",     {63'd0, error}, 64'd1);
    check("stray_rows_done", {32'd0, rows_done}, 64'd2);

    // Abort on the handshake cycle: abort wins, descriptor is still consumed.
    cfg_row_num = 32'd2;
    cfg_nnz_num = 32'd5;
    cfg_ctrl    = 32'd1;
    sb.push_back('{row: 32'd2, nnz: 32'd5});
    tick();
    cfg_ctrl        = 32'd2;
    bus.m_job_ready = 1'b1;
    tick();
    cfg_ctrl        = 32'd0;
    bus.m_job_ready = 1'b0;
    check("abort_hs_valid", {63'd0, bus.m_job_valid}, 64'd0);
    check("abort_hs_busy",  {63'd0, busy}, 64'd0);
    check("abort_hs_error", {63'd0, error}, 64'd1);
    check("abort_hs_done",  {63'd0, done}, 64'd0);
    tick();
    check("abort_hs_idle",  {63'd0, busy}, 64'd0);

    // Start held high across completion must not relaunch.
    cfg_row_num = 32'd1;
    cfg_nnz_num = 32'd1;
    cfg_ctrl    = 32'd1;
    sb.push_back('{row: 32'd1, nnz: 32'd1});
    tick();
    bus.m_job_ready = 1'b1;
    tick();
    bus.m_job_ready      = 1'b0;
    bus.s_row_done_valid = 1'b1;
    tick();
    bus.s_row_done_valid = 1'b0;
    check("held_done",  {63'd0, done}, 64'd1);
    check("held_error", {63'd0, error}, 64'd0);
    bus.m_job_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.m_job_ready = 1'b0;
    check("held_no_relaunch_busy", {63'd0, busy}, 64'd0);
    check("held_no_relaunch_done", {63'd0, done}, 64'd1);

    // Launch while busy is ignored, then an asynchronous reset mid-run.
    cfg_ctrl = 32'd0;
    tick();
    cfg_row_num = 32'd3;
    cfg_nnz_num = 32'd4;
    cfg_ctrl    = 32'd1;
    sb.push_back('{row: 32'd3, nnz: 32'd4});
    tick();
    bus.m_job_ready = 1'b1;
    tick();
    bus.m_job_ready      = 1'b0;
    bus.s_row_done_valid = 1'b1;
    tick();
    bus.s_row_done_valid = 1'b0;
    cfg_ctrl = 32'd0;
    tick();
    cfg_row_num = 32'd9;
    cfg_ctrl    = 32'd1;
    tick();
    check("busy_launch_row_num", {32'd0, bus.m_job_row_num}, 64'd3);
    check("busy_launch_busy",    {63'd0, busy}, 64'd1);
    check("busy_launch_rows",    {32'd0, rows_done}, 64'd1);
    #3;
    areset = 1'b1;
    #1;
    check("arst_busy",        {63'd0, busy}, 64'd0);
    check("arst_job_valid",   {63'd0, bus.m_job_valid}, 64'd0);
    check("arst_row_ready",   {63'd0, bus.s_row_done_ready}, 64'd1);
    check("arst_rows_done",   {32'd0, rows_done}, 64'd0);
    check("arst_cycle_count", {32'd0, cycle_count}, 64'd0);
    check("arst_row_num",     {32'd0, bus.m_job_row_num}, 64'd0);
    cfg_ctrl = 32'd0;
    tick();
    areset = 1'b0;
    tick();
    check("post_rst_busy", {63'd0, busy}, 64'd0);

    check("scoreboard_drained", sb.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
